// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, default widths and the
// divide-by-zero result constants.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  localparam int unsigned DIV_DW = 16;
  localparam int unsigned DIV_VW = 8;

  localparam logic [DIV_DW-1:0] DIV_Q_DBZ = '1;
  localparam logic [DIV_VW-1:0] DIV_R_DBZ = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, and keep the difference only when it does not go negative.
module div_step #(
  parameter int unsigned VW = 8
) (
  input  logic [VW:0]   p_i,
  input  logic          bit_i,
  input  logic [VW-1:0] dvs_i,
  output logic [VW:0]   p_o,
  output logic          q_o
);

  logic [VW:0] t;
  // P stays below the divisor, so its top bit is always zero here.
  logic        p_msb_unused;

  assign p_msb_unused = p_i[VW];

  always_comb begin
    t   = {p_i[VW-1:0], bit_i};
    q_o = (t >= {1'b0, dvs_i});
    p_o = q_o ? (t - {1'b0, dvs_i}) : t;
  end

endmodule

// File: rtl/seq_divider_16by8.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one
// quotient bit per clock, with a start/done handshake.
module seq_divider_16by8
  import alu_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] Z,
  input  logic [VW-1:0] Y,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          div_by_zero
);

  localparam int unsigned CW = $clog2(DW);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   p_q, p_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   p_nxt;
  logic          qbit;

  div_step #(.VW(VW)) u_step (
    .p_i   (p_q),
    .bit_i (dvd_q[DW-1]),
    .dvs_i (dvs_q),
    .p_o   (p_nxt),
    .q_o   (qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    case (state_q)
      // DONE accepts a new start exactly like IDLE so divides can run back-to-back.
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (Y != '0) begin
            dvd_d   = Z;
            dvs_d   = Y;
            p_d     = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            q_d     = DW'(DIV_Q_DBZ);
            r_d     = VW'(DIV_R_DBZ);
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        p_d   = p_nxt;
        dvd_d = {dvd_q[DW-2:0], 1'b0};
        quo_d = {quo_q[DW-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) begin
          q_d     = {quo_q[DW-2:0], qbit};
          r_d     = p_nxt[VW-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Scoreboard bench for seq_divider_16by8: expected Q/R/flag queued at start,
// compared on every done pulse, and held outputs checked on all other cycles.
module tb_seq_divider_16by8;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] Z;
  logic [7:0]  Y;
  logic        busy;
  logic        done;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        div_by_zero;

  int   n_vec = 0;
  int   n_err = 0;
  res_t sb[$];
  res_t held = '0;

  seq_divider_16by8 #(.DW(16), .VW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .Z           (Z),
    .Y           (Y),
    .busy        (busy),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; start is dropped by wait_done on the next one.
  task automatic issue(input logic [15:0] z, input logic [7:0] y);
    res_t e;
    start = 1'b1;
    Z     = z;
    Y     = y;
    if (y == 8'd0) e = '{16'hFFFF, 8'hFF, 1'b1};
    else           e = '{z / {8'd0, y}, 8'(z % {8'd0, y}), 1'b0};
    sb.push_back(e);
  endtask

  task automatic wait_done(output int lat, output int bc, input bit noise);
    lat = 0;
    bc  = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bc++;
      if (done) break;
      if (lat >= 64) begin
        check("timeout", 32'd0, 32'd1);
        break;
      end
      if (noise && busy) begin
        start = 1'($urandom_range(0, 1));
        Z     = 16'($urandom);
        Y     = 8'($urandom);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          held = sb.pop_front();
          check("Q",   32'(Q),           32'(held.q));
          check("R",   32'(R),           32'(held.r));
          check("dbz", 32'(div_by_zero), 32'(held.dbz));
        end
      end else begin
        check("hold", 32'({Q, R, div_by_zero}), 32'(held));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1);
  end

  logic [15:0] bz[4] = '{16'd65535, 16'd5, 16'd0, 16'd65535};
  logic [7:0]  by[4] = '{8'd255, 8'd200, 8'd1, 8'd1};

  initial begin
    int lat, bc;
    rst   = 1'b1;
    start = 1'b0;
    Z     = '0;
    Y     = '0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out",  32'({Q, R, div_by_zero}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic divide with latency and busy-length checks.
    @(negedge clk);
    issue(16'd1000, 8'd7);
    wait_done(lat, bc, 1'b0);
    check("t1_lat",  32'(lat), 32'd17);
    check("t1_busy", 32'(bc),  32'd16);
    check("t1_Q",    32'(Q),   32'd142);
    check("t1_R",    32'(R),   32'd6);

    // Boundary operands.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue(bz[i], by[i]);
      wait_done(lat, bc, 1'b0);
      check("t2_lat", 32'(lat), 32'd17);
    end

    // Divide by zero, then a valid divide clears the flag.
    @(negedge clk);
    issue(16'd1234, 8'd0);
    wait_done(lat, bc, 1'b0);
    check("t3_lat",  32'(lat), 32'd1);
    check("t3_busy", 32'(bc),  32'd0);
    check("t3_dbz",  32'(div_by_zero), 32'd1);
    @(negedge clk);
    issue(16'd10, 8'd3);
    wait_done(lat, bc, 1'b0);
    check("t3_clr", 32'(div_by_zero), 32'd0);

    // Start during RUN is ignored; start in DONE is accepted.
    @(negedge clk);
    issue(16'd100, 8'd3);
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b1;
    Z     = 16'd9;
    Y     = 8'd9;
    wait_done(lat, bc, 1'b0);
    check("t4_Q1", 32'(Q), 32'd33);
    check("t4_R1", 32'(R), 32'd1);
    issue(16'd9, 8'd9);
    wait_done(lat, bc, 1'b0);
    check("t4_lat", 32'(lat), 32'd17);
    check("t4_Q2",  32'(Q),   32'd1);
    check("t4_R2",  32'(R),   32'd0);

    // Asynchronous reset mid-RUN aborts without a done pulse.
    @(negedge clk);
    issue(16'd1000, 8'd7);
    repeat (8) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    rst = 1'b1;
    sb.delete();
    held = '0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_out",  32'({Q, R, div_by_zero}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(16'd50, 8'd5);
    wait_done(lat, bc, 1'b0);
    check("t5_Q", 32'(Q), 32'd10);
    check("t5_R", 32'(R), 32'd0);

    // Random regression with start/operand noise while busy.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      issue(16'($urandom), 8'($urandom_range(1, 255)));
      wait_done(lat, bc, 1'b1);
    end

    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
